// File: rtl/move_picker_if.sv
// rtl/move_picker_if.sv - pick request/response bundle between move_picker and the search controller
//
// Purpose: carries one best-first pick per request from the picker back to the search.
// Signals:
//   pick_req    controller -> picker  request the next-best move
//   pick_valid  picker -> controller  one-cycle pulse, pick_index/pick_eval valid
//   pick_index  picker -> controller  selected move index, held until the next pick
//   pick_eval   picker -> controller  raw eval of the selected move
//   pick_done   picker -> controller  level, every move returned (or empty list)
//   pick_busy   picker -> controller  scan in progress
// Modports: master = search controller, slave = move_picker.

interface move_picker_if #(
   parameter int IDX_W      = 8,
   parameter int EVAL_WIDTH = 24
);
   logic                         pick_req;
   logic                         pick_valid;
   logic [IDX_W-1:0]             pick_index;
   logic signed [EVAL_WIDTH-1:0] pick_eval;
   logic                         pick_done;
   logic                         pick_busy;

   modport master (
      output pick_req,
      input  pick_valid, pick_index, pick_eval, pick_done, pick_busy
   );

   modport slave (
      input  pick_req,
      output pick_valid, pick_index, pick_eval, pick_done, pick_busy
   );
endinterface

// File: rtl/move_picker.sv
// rtl/move_picker.sv - best-first move selector over the all_moves list
//
// Purpose: scans the finished move list once per request and returns the best
// not-yet-returned move, ordered PV first, then captures, then eval from the
// side to move's point of view; lowest index wins ties.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   am_moves_ready    list complete (sampled in IDLE)
//   am_move_count     number of moves in the list
//   white_to_move_in  side to move at the list's root
//   list_clear        discard the list, highest priority
//   am_move_index     read address into all_moves
//   eval_in, capture_in, pv_in  data of the addressed move, RD_LAT cycles after the address
//   pick              move_picker_if slave modport (request/response)

module move_picker #(
   parameter int MAX_POSITIONS_LOG2 = 8,
   parameter int EVAL_WIDTH         = 24,
   parameter int RD_LAT             = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          am_moves_ready,
   input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
   input  logic                          white_to_move_in,
   input  logic                          list_clear,
   output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
   input  logic signed [EVAL_WIDTH-1:0]  eval_in,
   input  logic                          capture_in,
   input  logic                          pv_in,
   move_picker_if.slave                  pick
);
   localparam int IW     = MAX_POSITIONS_LOG2;
   localparam int KW     = EVAL_WIDTH + 3;
   localparam int NMOVES = 2 ** IW;

   typedef enum logic [2:0] {
      IDLE, READY, SCAN_ISSUE, SCAN_WAIT, SCAN_CMP, EMIT
   } state_t;

   state_t                       state_q, state_d;
   logic [IW-1:0]                count_q, count_d;
   logic [IW-1:0]                i_q, i_d;
   logic [IW-1:0]                picked_q, picked_d;
   logic [IW-1:0]                best_idx_q, best_idx_d;
   logic [IW-1:0]                am_move_index_q, am_move_index_d;
   logic [IW-1:0]                pick_index_q, pick_index_d;
   logic                         wtm_q, wtm_d;
   logic                         best_valid_q, best_valid_d;
   logic                         done_q, done_d;
   logic                         pick_valid_q, pick_valid_d;
   logic [NMOVES-1:0]            used_q, used_d;
   logic [2:0]                   wait_q, wait_d;
   logic [KW-1:0]                best_key_q, best_key_d;
   logic signed [EVAL_WIDTH-1:0] best_eval_q, best_eval_d;
   logic signed [EVAL_WIDTH-1:0] pick_eval_q, pick_eval_d;
   logic signed [EVAL_WIDTH:0]   cand_s;
   logic [KW-1:0]                cand_key;

   // One extra bit keeps the negation of the most negative eval in range.
   // Flipping the sign bit of s turns the whole key into a plain unsigned compare.
   always_comb begin
      cand_s = {eval_in[EVAL_WIDTH-1], eval_in};
      if (!wtm_q) begin
         cand_s = -cand_s;
      end
      cand_key = {pv_in, capture_in, ~cand_s[EVAL_WIDTH], cand_s[EVAL_WIDTH-1:0]};
   end

   always_comb begin
      state_d         = state_q;
      count_d         = count_q;
      i_d             = i_q;
      picked_d        = picked_q;
      best_idx_d      = best_idx_q;
      am_move_index_d = am_move_index_q;
      pick_index_d    = pick_index_q;
      wtm_d           = wtm_q;
      best_valid_d    = best_valid_q;
      done_d          = done_q;
      pick_valid_d    = 1'b0;
      used_d          = used_q;
      wait_d          = wait_q;
      best_key_d      = best_key_q;
      best_eval_d     = best_eval_q;
      pick_eval_d     = pick_eval_q;

      case (state_q)
         IDLE: begin
            if (am_moves_ready) begin
               count_d  = am_move_count;
               wtm_d    = white_to_move_in;
               used_d   = '0;
               picked_d = '0;
               done_d   = (am_move_count == '0);
               state_d  = READY;
            end
         end
         READY: begin
            if (pick.pick_req && !done_q) begin
               i_d          = '0;
               best_valid_d = 1'b0;
               state_d      = SCAN_ISSUE;
            end
         end
         SCAN_ISSUE: begin
            if (i_q == count_q) begin
               // Outputs are registered here so they are valid throughout EMIT.
               pick_valid_d = 1'b1;
               pick_index_d = best_idx_q;
               pick_eval_d  = best_eval_q;
               state_d      = EMIT;
            end else if (used_q[i_q]) begin
               i_d = i_q + 1'b1;
            end else begin
               am_move_index_d = i_q;
               wait_d          = 3'(RD_LAT);
               state_d         = SCAN_WAIT;
            end
         end
         SCAN_WAIT: begin
            wait_d = wait_q - 3'd1;
            if (wait_d == 3'd0) begin
               state_d = SCAN_CMP;
            end
         end
         SCAN_CMP: begin
            // Strict greater-than keeps the earlier index on ties.
            if (!best_valid_q || (cand_key > best_key_q)) begin
               best_valid_d = 1'b1;
               best_key_d   = cand_key;
               best_idx_d   = i_q;
               best_eval_d  = eval_in;
            end
            i_d     = i_q + 1'b1;
            state_d = SCAN_ISSUE;
         end
         EMIT: begin
            used_d[best_idx_q] = 1'b1;
            picked_d           = picked_q + 1'b1;
            if (picked_d == count_q) begin
               done_d = 1'b1;
            end
            state_d = READY;
         end
         default: state_d = IDLE;
      endcase

      if (list_clear) begin
         state_d      = IDLE;
         done_d       = 1'b0;
         used_d       = '0;
         picked_d     = '0;
         pick_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         count_q         <= '0;
         i_q             <= '0;
         picked_q        <= '0;
         best_idx_q      <= '0;
         am_move_index_q <= '0;
         pick_index_q    <= '0;
         wtm_q           <= 1'b0;
         best_valid_q    <= 1'b0;
         done_q          <= 1'b0;
         pick_valid_q    <= 1'b0;
         used_q          <= '0;
         wait_q          <= '0;
         best_key_q      <= '0;
         best_eval_q     <= '0;
         pick_eval_q     <= '0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         i_q             <= i_d;
         picked_q        <= picked_d;
         best_idx_q      <= best_idx_d;
         am_move_index_q <= am_move_index_d;
         pick_index_q    <= pick_index_d;
         wtm_q           <= wtm_d;
         best_valid_q    <= best_valid_d;
         done_q          <= done_d;
         pick_valid_q    <= pick_valid_d;
         used_q          <= used_d;
         wait_q          <= wait_d;
         best_key_q      <= best_key_d;
         best_eval_q     <= best_eval_d;
         pick_eval_q     <= pick_eval_d;
      end
   end

   assign am_move_index   = am_move_index_q;
   assign pick.pick_valid = pick_valid_q;
   assign pick.pick_index = pick_index_q;
   assign pick.pick_eval  = pick_eval_q;
   assign pick.pick_done  = done_q;
   assign pick.pick_busy  = (state_q == SCAN_ISSUE) || (state_q == SCAN_WAIT) ||
                            (state_q == SCAN_CMP)   || (state_q == EMIT);
endmodule
